// File: rtl/fc_pkg.sv
// Shared types and width helpers for the FC-layer weight loader.
package fc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } fc_state_e;

  // $clog2 with a floor of 1 so a single-entry range still has a real bit.
  function automatic int unsigned clog2_min1(input int unsigned val);
    return (val <= 1) ? 1 : $clog2(val);
  endfunction

endpackage

// File: rtl/fc_weight_loader_wrap_counter.sv
// Up-counter from RESET_VAL to MAX that wraps back to RESET_VAL; clear has priority.
module wrap_counter #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned MAX       = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;

  // Wrap flag is a pure decode of the current count.
  always_comb begin
    at_max = (count_q == MaxVal);
  end

  // Next count: clear, wrap at MAX, or increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = ResetVal;
    end else if (inc) begin
      count_d = at_max ? ResetVal : count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= ResetVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fc_weight_loader.sv
// FC weight loader: frames a NUM x NW weight stream into per-neuron RAM writes.
module fc_weight_loader
  import fc_pkg::*;
#(
  parameter int unsigned WD    = 8,
  parameter int unsigned NW    = 256,
  parameter int unsigned NUM   = 120,
  parameter int unsigned LANES = 1,
  localparam int unsigned DEPTH = NW / LANES,
  localparam int unsigned AW    = clog2_min1(DEPTH),
  localparam int unsigned NUMW  = clog2_min1(NUM + 1)
) (
  input  logic                  i_sclk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [WD*LANES-1:0]   i_weight_data,
  input  logic                  i_weight_valid,
  output logic                  o_weight_ready,
  output logic                  o_w_en,
  output logic [NUMW-1:0]       o_w_num,
  output logic [AW-1:0]         o_w_addr,
  output logic [WD*LANES-1:0]   o_weight,
  output logic                  o_row_last,
  output logic                  o_done,
  output logic                  o_busy,
  output logic                  o_err_overrun
);

  if (NW % LANES != 0) begin : g_bad_lanes
    $error("fc_weight_loader: NW must be a multiple of LANES");
  end
  if (NUM < 1) begin : g_bad_num
    $error("fc_weight_loader: NUM must be at least 1");
  end

  fc_state_e state_q, state_d;

  logic            ready;
  logic            accept;
  logic            cnt_clr;
  logic            err_clr;
  logic            err_set;
  logic [AW-1:0]   addr;
  logic [NUMW-1:0] num;
  logic            addr_last;
  logic            num_last;

  logic                err_q;
  logic                w_en_q;
  logic                row_last_q;
  logic [AW-1:0]       w_addr_q;
  logic [NUMW-1:0]     w_num_q;
  logic [WD*LANES-1:0] weight_q;

  assign ready  = (state_q == StLoad);
  // A restart in LOAD drops whatever beat is presented alongside it.
  assign accept = i_weight_valid & ready & ~i_start;

  // Next-state, counter clear and overrun flag control.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    err_clr = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StLoad;
          cnt_clr = 1'b1;
          err_clr = 1'b1;
        end else if (i_weight_valid) begin
          err_set = 1'b1;
        end
      end
      StLoad: begin
        if (i_start) begin
          cnt_clr = 1'b1;
          err_clr = 1'b1;
        end else if (accept && addr_last && num_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (i_weight_valid) begin
          err_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and sticky overrun flag.
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_clr) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  wrap_counter #(
    .WIDTH     (AW),
    .MAX       (DEPTH - 1),
    .RESET_VAL (0)
  ) u_addr_cnt (
    .clk    (i_sclk),
    .rst_n  (i_rstn),
    .clr    (cnt_clr),
    .inc    (accept),
    .count  (addr),
    .at_max (addr_last)
  );

  // Neuron index is 1-based and only advances at the end of a row.
  wrap_counter #(
    .WIDTH     (NUMW),
    .MAX       (NUM),
    .RESET_VAL (1)
  ) u_num_cnt (
    .clk    (i_sclk),
    .rst_n  (i_rstn),
    .clr    (cnt_clr),
    .inc    (accept & addr_last),
    .count  (num),
    .at_max (num_last)
  );

  // Registered RAM write port; data/address hold between writes.
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      w_en_q     <= 1'b0;
      row_last_q <= 1'b0;
      w_addr_q   <= '0;
      w_num_q    <= NUMW'(1);
      weight_q   <= '0;
    end else begin
      w_en_q     <= accept;
      row_last_q <= accept & addr_last;
      if (accept) begin
        w_addr_q <= addr;
        w_num_q  <= num;
        weight_q <= i_weight_data;
      end
    end
  end

  assign o_weight_ready = ready;
  assign o_busy         = ready;
  assign o_done         = (state_q == StDone);
  assign o_err_overrun  = err_q;
  assign o_w_en         = w_en_q;
  assign o_row_last     = row_last_q;
  assign o_w_addr       = w_addr_q;
  assign o_w_num        = w_num_q;
  assign o_weight       = weight_q;

endmodule

// File: tb/tb_fc_weight_loader.sv
// Directed bench for fc_weight_loader in two configurations.
module tb_fc_weight_loader;

  logic clk;
  logic rstn;

  // Config A: NW=4, NUM=3, LANES=1 (DEPTH=4, AW=2, NUMW=2).
  logic       a_start, a_valid, a_ready, a_w_en, a_row_last, a_done, a_busy, a_err;
  logic [7:0] a_data, a_weight;
  logic [1:0] a_w_num, a_w_addr;

  // Config B: NW=8, NUM=2, LANES=4 (DEPTH=2, AW=1, NUMW=2).
  logic        b_start, b_valid, b_ready, b_w_en, b_row_last, b_done, b_busy, b_err;
  logic [31:0] b_data, b_weight;
  logic [1:0]  b_w_num;
  logic [0:0]  b_w_addr;

  int n_cmp = 0;
  int n_err = 0;

  fc_weight_loader #(.WD(8), .NW(4), .NUM(3), .LANES(1)) dut_a (
    .i_sclk(clk), .i_rstn(rstn), .i_start(a_start), .i_weight_data(a_data),
    .i_weight_valid(a_valid), .o_weight_ready(a_ready), .o_w_en(a_w_en),
    .o_w_num(a_w_num), .o_w_addr(a_w_addr), .o_weight(a_weight),
    .o_row_last(a_row_last), .o_done(a_done), .o_busy(a_busy), .o_err_overrun(a_err)
  );

  fc_weight_loader #(.WD(8), .NW(8), .NUM(2), .LANES(4)) dut_b (
    .i_sclk(clk), .i_rstn(rstn), .i_start(b_start), .i_weight_data(b_data),
    .i_weight_valid(b_valid), .o_weight_ready(b_ready), .o_w_en(b_w_en),
    .o_w_num(b_w_num), .o_w_addr(b_w_addr), .o_weight(b_weight),
    .o_row_last(b_row_last), .o_done(b_done), .o_busy(b_busy), .o_err_overrun(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_go();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  // One accepted beat on A with its expected write tag.
  task automatic a_beat(input int unsigned idx, input logic [7:0] d);
    a_valid = 1'b1;
    a_data  = d;
    tick();
    a_valid = 1'b0;
    chk("a_wen",   a_w_en, 1);
    chk("a_num",   a_w_num, idx / 4 + 1);
    chk("a_addr",  a_w_addr, idx % 4);
    chk("a_data",  a_weight, d);
    chk("a_last",  a_row_last, (idx % 4) == 3);
    chk("a_done",  a_done, idx == 11);
    chk("a_ready", a_ready, idx != 11);
  endtask

  initial begin
    int k;
    rstn = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen",   a_w_en, 0);
    chk("rst_num",   a_w_num, 1);
    chk("rst_addr",  a_w_addr, 0);
    chk("rst_data",  a_weight, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_busy",  a_busy, 0);
    chk("rst_done",  a_done, 0);
    chk("rst_err",   a_err, 0);
    rstn = 1'b1;
    tick();

    // Back-to-back full load.
    a_go();
    chk("bb_busy", a_busy, 1);
    chk("bb_ready", a_ready, 1);
    for (int i = 0; i < 12; i++) a_beat(i, 8'(i));
    tick();
    chk("bb_idle_busy", a_busy, 0);
    chk("bb_idle_done", a_done, 0);
    chk("bb_idle_wen",  a_w_en, 0);
    chk("bb_err",       a_err, 0);

    // Valid toggling every other cycle: counters hold across gaps.
    a_go();
    k = 0;
    for (int c = 0; c < 24; c++) begin
      if (c % 2 == 0) begin
        a_beat(k, 8'(8'h40 + k));
        k++;
      end else begin
        tick();
        chk("gap_wen",  a_w_en, 0);
        chk("gap_addr", a_w_addr, (k - 1) % 4);
      end
    end
    chk("gap_idle", a_busy, 0);

    // Overrun in IDLE, sticky until the next start.
    a_valid = 1'b1; a_data = 8'hEE;
    tick();
    a_valid = 1'b0;
    chk("ovr_wen", a_w_en, 0);
    chk("ovr_err", a_err, 1);
    tick();
    chk("ovr_hold", a_err, 1);
    chk("ovr_data_hold", a_weight, 8'h4B);
    a_go();
    chk("ovr_clr", a_err, 0);
    for (int i = 0; i < 12; i++) a_beat(i, 8'(8'h80 + i));

    // Start during DONE is ignored.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("done_start_busy", a_busy, 0);
    chk("done_start_ready", a_ready, 0);

    // Restart after five beats with a beat presented in the same cycle.
    a_go();
    for (int i = 0; i < 5; i++) a_beat(i, 8'(8'h10 + i));
    a_start = 1'b1; a_valid = 1'b1; a_data = 8'hAA;
    tick();
    a_start = 1'b0; a_valid = 1'b0;
    chk("rs_drop_wen", a_w_en, 0);
    chk("rs_busy", a_busy, 1);
    for (int i = 0; i < 12; i++) a_beat(i, 8'(8'hC0 + i));
    tick();

    // Asynchronous reset mid-row, next write would have been (2,2).
    a_go();
    for (int i = 0; i < 6; i++) a_beat(i, 8'(8'h20 + i));
    a_valid = 1'b1; a_data = 8'h55;
    #2 rstn = 1'b0;
    #1;
    chk("ar_wen",  a_w_en, 0);
    chk("ar_num",  a_w_num, 1);
    chk("ar_addr", a_w_addr, 0);
    chk("ar_data", a_weight, 0);
    chk("ar_busy", a_busy, 0);
    chk("ar_ready", a_ready, 0);
    a_valid = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_no_done", a_done, 0);
      chk("ar_idle", a_busy, 0);
    end
    a_go();
    a_beat(0, 8'h99);

    // Four-lane packing on config B.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1;
      b_data  = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      tick();
      b_valid = 1'b0;
      chk("b_wen",  b_w_en, 1);
      chk("b_addr", b_w_addr, i % 2);
      chk("b_num",  b_w_num, i / 2 + 1);
      chk("b_data", b_weight, {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
      chk("b_last", b_row_last, (i % 2) == 1);
      chk("b_done", b_done, i == 3);
    end
    tick();
    chk("b_idle", b_busy, 0);
    chk("b_err",  b_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fc_weight_loader.md
Name: fc_weight_loader

Overview:
Parametrised successor of the FC-layer weight buffer front end. It accepts a stream of fully-connected weights over a valid/ready handshake, LANES weights per beat, and tags each beat with a 1-based neuron index and an in-row beat address. It drives the per-neuron weight RAM write port of the FC layers (F5/F6 and later). Over the earlier free-running counter scheme it adds explicit start/done framing, backpressure, multi-lane packing, row-last marking and overrun detection.

Parameters:
WD, 8, bit width of one weight
NW, 256, weights per neuron (row length); must be a multiple of LANES
NUM, 120, number of neurons (rows) per load
LANES, 1, weights carried per input beat
DEPTH, NW/LANES, beats per row (derived, not overridable)
AW, $clog2(DEPTH) (min 1), beat-address width (derived)
NUMW, $clog2(NUM+1), neuron-index width (derived)

Ports:
i_sclk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_start  in  1  single-cycle pulse; arms or restarts a full NUM x NW load
i_weight_data  in  WD*LANES  packed weights; lane 0 in the LSBs = lowest weight index
i_weight_valid  in  1  beat valid
o_weight_ready  out  1  loader accepts a beat this cycle
o_w_en  out  1  RAM write enable, one cycle per accepted beat
o_w_num  out  NUMW  1-based neuron index of the current write
o_w_addr  out  AW  beat address within the row, 0..DEPTH-1
o_weight  out  WD*LANES  registered copy of the accepted beat
o_row_last  out  1  high with o_w_en on the last beat of each row
o_done  out  1  one-cycle pulse after the final beat is written
o_busy  out  1  high while in LOAD
o_err_overrun  out  1  sticky; a beat was presented while not in LOAD

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_w_en=0, o_w_addr=0, o_w_num=1, o_weight=0, o_row_last=0, o_done=0, o_busy=0, o_err_overrun=0, o_weight_ready=0. Internal counters: addr=0, num=1.
- FSM states: IDLE, LOAD, DONE.
- IDLE: ready=0. i_start -> LOAD; addr=0, num=1, o_err_overrun cleared.
- LOAD: ready=1 (combinational from state). A beat is accepted when valid & ready.
- Accepted beat: on the next edge o_w_en=1, o_weight=data, o_w_addr=addr, o_w_num=num, o_row_last=(addr==DEPTH-1). Latency is 1 cycle. Outputs hold their last values when o_w_en=0.
- Counter update on accept: if addr==DEPTH-1 then addr=0 and num=num+1, else addr=addr+1.
- Final beat (addr==DEPTH-1 and num==NUM): counters return to 0/1 and the FSM moves to DONE. This beat's o_w_en and the DONE state fall in the same cycle.
- DONE: o_done=1 for exactly that cycle, ready=0, then -> IDLE unconditionally.
- i_start while in LOAD: abort and restart. Counters go to 0/1, and any beat presented in that cycle is dropped (no o_w_en). i_start in DONE is ignored.
- valid while in IDLE or DONE: the beat is dropped and o_err_overrun is set. It stays set until i_start or reset.
- Gaps in valid are legal; counters hold.
- Reset asserted mid-load aborts immediately with no o_done; all state returns to reset values.
- All arithmetic is unsigned. Counter widths are AW/NUMW with no overflow beyond the wrap points. DEPTH=1 is legal: every beat is a row-last beat.
- Elaboration error if NW % LANES != 0 or NUM < 1.

Decomposition:
- Shared package fc_pkg holds the FSM state typedef (IDLE/LOAD/DONE) and a clog2-with-minimum-1 width function. Derived widths are computed there.
- One natural sub-module, wrap_counter (params WIDTH, MAX, RESET_VAL): increment-enable, synchronous clear, wrap flag. It is instantiated twice, for addr (0..DEPTH-1) and num (1..NUM).

Test Plan:
- NW=4, NUM=3, LANES=1; start, then 12 back-to-back beats 0..11 -> 12 o_w_en pulses, (num,addr) = (1,0)..(3,3), o_row_last on beats 3, 7 and 11, o_done one cycle after beat 11, ready low in DONE.
- Same config, valid toggling every other cycle -> identical addr/num sequence, no extra o_w_en, o_done after the 12th accepted beat.
- NW=8, LANES=4, NUM=2; 4 beats -> o_w_addr 0,1,0,1, o_w_num 1,1,2,2, o_weight equals the input word with lane order preserved, o_row_last on beats 1 and 3.
- Valid high in IDLE before any start -> no o_w_en, o_err_overrun=1 and held; then i_start -> o_err_overrun=0, load proceeds normally.
- i_start after 5 beats of a load, with valid high in the same cycle -> that beat is dropped, next accepted beat writes (1,0), full 12 beats are required for o_done.
- i_rstn pulsed low mid-row (addr=2, num=2) -> outputs return to reset values asynchronously, o_done never fires, FSM in IDLE after release.
